alu_writeback_unit: RTL
=======================

# alu_writeback_unit

In-order retirement stage on the result side of `alu_pipe`. It captures each completed ALU result, identified by its 4-bit instruction tag, into a tag-indexed completion table. It then retires entries strictly in tag order, one per cycle, to the register-file write port and the CPSR. Tags are allocated sequentially by the issue stage, and the retire strobe is the signal that frees a tag back to it.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of rd data and CPSR
- `TAG_WIDTH`, 4, tag width; table depth = 2**TAG_WIDTH (16)

Ports:
- `clk_in`  in  1  clock; all state updates on rising edge
- `reset_in`  in  1  asynchronous, active-low reset
- `flush_in`  in  1  synchronous flush of all in-flight results
- `alu_complete_in`  in  1  result valid this cycle (driven from `instr_exec_complete_out`)
- `alu_confirmed_in`  in  1  condition passed, so writes are committed (driven from `instr_exec_confirmed_out`)
- `alu_tag_in`  in  TAG_WIDTH  tag of the result
- `alu_rd_addr_in`  in  4  destination register
- `alu_rd_data_in`  in  DATA_WIDTH  result data
- `alu_cpsr_in`  in  DATA_WIDTH  updated CPSR
- `rf_wr_en_out`  out  1  register-file write strobe, one cycle
- `rf_wr_addr_out`  out  4  write address
- `rf_wr_data_out`  out  DATA_WIDTH  write data
- `cpsr_wr_en_out`  out  1  CPSR write strobe, one cycle
- `cpsr_out`  out  DATA_WIDTH  last retired committed CPSR
- `retire_valid_out`  out  1  one tag retired this cycle
- `retire_tag_out`  out  TAG_WIDTH  retired tag
- `head_tag_out`  out  TAG_WIDTH  next tag expected to retire
- `protocol_err_out`  out  1  sticky: a result arrived for an already-occupied tag

## Operation
- Each table entry holds: valid, confirmed, rd_addr, rd_data, cpsr.
- **Capture.** When `alu_complete_in`=1 and entry[`alu_tag_in`] is invalid, the entry is written and marked valid.
- **Duplicate result.** When `alu_complete_in`=1 and entry[`alu_tag_in`] is already valid:
  - the new result is dropped;
  - the stored entry is unchanged;
  - `protocol_err_out` is set and stays set until reset.
- **Retire.** Each cycle, if entry[head] is valid:
  - `retire_valid_out`=1 and `retire_tag_out`=head, registered;
  - entry[head] is cleared;
  - head increments modulo 2**TAG_WIDTH (15 wraps to 0).
- **Confirmed retire.** If the retiring entry is confirmed:
  - `rf_wr_en_out`=1, with `rf_wr_addr_out` and `rf_wr_data_out` taken from the entry;
  - `cpsr_wr_en_out`=1 and `cpsr_out` is updated from the entry.
- **Unconfirmed retire.** The tag retires but both write strobes stay 0. Addr, data and `cpsr_out` hold their previous values.
- Retirement rate is at most one entry per cycle. Out-of-order completions wait until every older tag has retired.
- **Flush.** `flush_in`=1 clears all valid bits and sets head to 0. Output strobes are 0 in the following cycle. A completion presented in the flush cycle is dropped.
- **Priority:** reset > flush > capture/retire.
- **Reset.** All outputs are 0, head is 0, all entries are invalid and `protocol_err_out` is 0. Reset asserted mid-stream discards everything in flight.

## Timing
- All outputs are registered.
- Strobes (`rf_wr_en_out`, `cpsr_wr_en_out`, `retire_valid_out`) are high for exactly one cycle per retired tag.
- Base latency: a completion sampled at edge N for tag == head is visible on the outputs after edge N+1.
- A completion for a non-head tag retires at least one cycle after its predecessor retires.
- Back-to-back in-order completions retire one per cycle with no bubbles.
- Capture and retire of different tags in the same cycle are both performed.
- A completion for the current head tag while head is valid is a duplicate: error set, and the stored entry retires as normal.
- `head_tag_out` reflects head after each edge.

## Configuration
- `ALU_WB_BYPASS_EN` defined:
  - a completion with tag == head and entry[head] invalid skips the table and drives the retire outputs directly at edge N, so outputs are visible after edge N (latency 1);
  - head advances at the same edge.
- Undefined: every result passes through the table (latency 2).
- Both builds produce identical retirement order and write values.

## Test plan
- **Reset.** Hold `reset_in`=0 mid-stream with 3 entries pending → all outputs 0 and head 0; after release, a completion for tag 0 retires normally.
- **In-order stream.** Tags 0,1,2 on consecutive cycles, confirmed, rd_addr=3, data 15,25,35 → three consecutive `rf_wr_en_out` pulses carrying those values, in order. Latency is 2 (1 with bypass).
- **Out-of-order.** Tag 2 (data 0xAA), then tag 1 (0xBB), then tag 0 (0xCC) → retirement order 0,1,2 with data 0xCC, 0xBB, 0xAA; retire cycles are consecutive after tag 0 arrives.
- **Unconfirmed.** Tag 0 arrives with confirmed=0 and cpsr=0xF0000000 → `retire_valid_out`=1 with both write strobes 0; `cpsr_out` unchanged at 0; head becomes 1.
- **Wrap and duplicate.** Retire tags 0..15, then tag 0 again → head wraps to 0 and the entry retires. Sending tag 5 twice before it retires → `protocol_err_out`=1, and the first data is the one retired.
- **Flush.** Tags 1 and 2 pending while head=0, then `flush_in`=1 → no retires occur and head=0. A new tag-0 completion then retires correctly.

Source files
------------

// File: rtl/alu_writeback_unit.sv
// alu_writeback_unit: in-order retirement stage behind alu_pipe.
// ALU results are captured into a tag-indexed completion table and retired
// strictly in tag order, one per cycle, to the register file and the CPSR.
// Optional build macro ALU_WB_BYPASS_EN: a completion for the head tag that
// finds its table entry empty skips the table and retires at the same edge.
module alu_writeback_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  flush_in,
  input  logic                  alu_complete_in,
  input  logic                  alu_confirmed_in,
  input  logic [TAG_WIDTH-1:0]  alu_tag_in,
  input  logic [3:0]            alu_rd_addr_in,
  input  logic [DATA_WIDTH-1:0] alu_rd_data_in,
  input  logic [DATA_WIDTH-1:0] alu_cpsr_in,
  output logic                  rf_wr_en_out,
  output logic [3:0]            rf_wr_addr_out,
  output logic [DATA_WIDTH-1:0] rf_wr_data_out,
  output logic                  cpsr_wr_en_out,
  output logic [DATA_WIDTH-1:0] cpsr_out,
  output logic                  retire_valid_out,
  output logic [TAG_WIDTH-1:0]  retire_tag_out,
  output logic [TAG_WIDTH-1:0]  head_tag_out,
  output logic                  protocol_err_out
);

  localparam int DEPTH = 2**TAG_WIDTH;

  logic [DEPTH-1:0]      tbl_vld;
  logic [DEPTH-1:0]      tbl_conf;
  logic [3:0]            tbl_rd_addr [DEPTH];
  logic [DATA_WIDTH-1:0] tbl_rd_data [DEPTH];
  logic [DATA_WIDTH-1:0] tbl_cpsr    [DEPTH];
  logic [TAG_WIDTH-1:0]  head;
  logic                  err;

  logic                  dup_p0;
  logic                  byp_p0;
  logic                  cap_p0;
  logic                  vld_p0;
  logic                  conf_p0;
  logic [3:0]            addr_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [DATA_WIDTH-1:0] cpsr_p0;

  logic                  vld_p1;
  logic [TAG_WIDTH-1:0]  tag_p1;
  logic                  rf_wr_en_p1;
  logic [3:0]            addr_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  cpsr_wr_en_p1;
  logic [DATA_WIDTH-1:0] cpsr_p1;

  // ---- stage p0: classify the incoming result and pick the retiring entry ----
  always_comb begin
    dup_p0 = alu_complete_in && tbl_vld[alu_tag_in];
`ifdef ALU_WB_BYPASS_EN
    byp_p0 = alu_complete_in && (alu_tag_in == head) && !tbl_vld[head];
`else
    byp_p0 = 1'b0;
`endif
    cap_p0  = alu_complete_in && !tbl_vld[alu_tag_in] && !byp_p0;
    vld_p0  = tbl_vld[head] || byp_p0;
    conf_p0 = tbl_conf[head];
    addr_p0 = tbl_rd_addr[head];
    data_p0 = tbl_rd_data[head];
    cpsr_p0 = tbl_cpsr[head];
    if (byp_p0) begin
      conf_p0 = alu_confirmed_in;
      addr_p0 = alu_rd_addr_in;
      data_p0 = alu_rd_data_in;
      cpsr_p0 = alu_cpsr_in;
    end
  end

  // Capture and retire always touch different entries: capture needs an
  // empty slot, retire needs a full one.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      tbl_vld <= '0;
      head    <= '0;
      err     <= 1'b0;
    end else if (flush_in) begin
      tbl_vld <= '0;
      head    <= '0;
    end else begin
      if (dup_p0) begin
        err <= 1'b1;
      end
      if (vld_p0) begin
        if (!byp_p0) begin
          tbl_vld[head] <= 1'b0;
        end
        head <= head + TAG_WIDTH'(1);
      end
      if (cap_p0) begin
        tbl_vld[alu_tag_in] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (cap_p0 && !flush_in) begin
      tbl_conf[alu_tag_in]    <= alu_confirmed_in;
      tbl_rd_addr[alu_tag_in] <= alu_rd_addr_in;
      tbl_rd_data[alu_tag_in] <= alu_rd_data_in;
      tbl_cpsr[alu_tag_in]    <= alu_cpsr_in;
    end
  end

  // ---- stage p1: registered retire / write-back outputs ----
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      vld_p1        <= 1'b0;
      tag_p1        <= '0;
      rf_wr_en_p1   <= 1'b0;
      addr_p1       <= '0;
      data_p1       <= '0;
      cpsr_wr_en_p1 <= 1'b0;
      cpsr_p1       <= '0;
    end else if (flush_in) begin
      vld_p1        <= 1'b0;
      rf_wr_en_p1   <= 1'b0;
      cpsr_wr_en_p1 <= 1'b0;
    end else begin
      vld_p1        <= vld_p0;
      rf_wr_en_p1   <= vld_p0 && conf_p0;
      cpsr_wr_en_p1 <= vld_p0 && conf_p0;
      if (vld_p0) begin
        tag_p1 <= head;
      end
      if (vld_p0 && conf_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
        cpsr_p1 <= cpsr_p0;
      end
    end
  end

  assign rf_wr_en_out     = rf_wr_en_p1;
  assign rf_wr_addr_out   = addr_p1;
  assign rf_wr_data_out   = data_p1;
  assign cpsr_wr_en_out   = cpsr_wr_en_p1;
  assign cpsr_out         = cpsr_p1;
  assign retire_valid_out = vld_p1;
  assign retire_tag_out   = tag_p1;
  assign head_tag_out     = head;
  assign protocol_err_out = err;

endmodule
